// File: rtl/z80_char_in_port_pkg.sv
// z80_char_in_port_pkg
//   Shared I/O definitions for the character input port: default port
//   addresses, status/control bit positions, the read-source selector and
//   the helper that assembles the status byte.
//   No ports (package).
package z80_char_in_port_pkg;

  localparam logic [7:0] DEF_DATA_PORT   = 8'hBA;
  localparam logic [7:0] DEF_STATUS_PORT = 8'hBC;

  // Status byte bit positions
  localparam int ST_AVAIL = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVR   = 2;

  // Control byte bit positions (OUT to the status port)
  localparam int CTL_CLR_OVR = 2;
  localparam int CTL_FLUSH   = 7;

  // What the CPU is reading this cycle
  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_DATA   = 2'd1,
    RD_STATUS = 2'd2
  } rd_sel_t;

  function automatic logic [7:0] status_byte(input logic ovr,
                                             input logic full,
                                             input logic avail);
    logic [7:0] s;
    s           = 8'h00;
    s[ST_OVR]   = ovr;
    s[ST_FULL]  = full;
    s[ST_AVAIL] = avail;
    return s;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// char_fifo
//   Single-clock synchronous byte FIFO. Head is a combinational read of the
//   storage array at the read pointer. Pushes into a full FIFO and pops from
//   an empty FIFO are ignored. Flush returns pointers and count to zero and
//   takes priority over a push/pop in the same cycle.
// Ports
//   clk    in   system clock
//   reset  in   async active-high reset
//   push   in   write wdata at the tail
//   pop    in   discard the head entry
//   flush  in   empty the FIFO
//   wdata  in   [7:0] byte to push
//   head   out  [7:0] current head entry (undefined content when empty)
//   count  out  [AW:0] number of stored entries, 0..DEPTH
module char_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage needs no reset; only entries behind a valid count are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/z80_char_in_port.sv
// z80_char_in_port
//   Z80 I/O-mapped character input port. Bytes arriving on char_stb are
//   queued in char_fifo; the CPU drains them with IN from DATA_PORT and
//   reads status / writes control at STATUS_PORT.
// Ports
//   clk         in   system clock
//   reset       in   async active-high reset
//   address     in   [7:0] CPU A[7:0]
//   iorq_n      in   I/O request, active low
//   rd_n        in   read strobe, active low
//   wr_n        in   write strobe, active low
//   dbus_in     in   [7:0] CPU OUT data
//   dbus_out    out  [7:0] registered read data to CPU
//   char_in     in   [7:0] incoming character
//   char_stb    in   one-cycle push strobe
//   char_ready  out  FIFO not full
//   rx_avail    out  FIFO not empty
//   overrun     out  sticky: strobe arrived while full
module z80_char_in_port
  import z80_char_in_port_pkg::*;
#(
  parameter logic [7:0] DATA_PORT   = DEF_DATA_PORT,
  parameter logic [7:0] STATUS_PORT = DEF_STATUS_PORT,
  parameter int         DEPTH       = 16,
  parameter int         AW          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  input  logic [7:0] char_in,
  input  logic       char_stb,
  output logic       char_ready,
  output logic       rx_avail,
  output logic       overrun
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic          rd_cyc, wr_cyc;
  logic          rd_cyc_q, wr_cyc_q;
  logic          rd_guard;
  logic          rd_rise, rd_fall, wr_rise;
  logic          data_hit, status_hit;
  logic          ctl_wr, flush, clr_ovr;
  logic          push, pop, ovr_set;
  logic          pop_pend;
  logic          overrun_q;
  logic [7:0]    fifo_head;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty;
  rd_sel_t       rd_sel;
  logic [7:0]    dbus_next;
  logic          unused_dbus;

  assign rd_cyc     = ~iorq_n & ~rd_n;
  assign wr_cyc     = ~iorq_n & ~wr_n;
  assign data_hit   = (address == DATA_PORT);
  assign status_hit = (address == STATUS_PORT);

  // rd_guard keeps a read that straddles reset release from looking like
  // a fresh rising edge; it drops on the first cycle the strobe is idle.
  assign rd_rise = rd_cyc & ~rd_cyc_q & ~rd_guard;
  assign rd_fall = rd_cyc_q & ~rd_cyc;
  assign wr_rise = wr_cyc & ~wr_cyc_q;

  assign ctl_wr  = wr_rise & status_hit;
  assign flush   = ctl_wr & dbus_in[CTL_FLUSH];
  assign clr_ovr = ctl_wr & dbus_in[CTL_CLR_OVR];

  assign fifo_full  = (fifo_count == DEPTH_CNT);
  assign fifo_empty = (fifo_count == '0);

  // Full is judged before any same-cycle pop, so there is no bypass path.
  // A flush swallows a coincident strobe entirely, including its overrun.
  assign push    = char_stb & ~fifo_full & ~flush;
  assign ovr_set = char_stb & fifo_full & ~flush;
  assign pop     = rd_fall & pop_pend & ~flush;

  assign unused_dbus = ^{dbus_in[6:3], dbus_in[1:0]};

  char_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (char_in),
    .head  (fifo_head),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cyc_q <= 1'b0;
      wr_cyc_q <= 1'b0;
      rd_guard <= 1'b1;
    end else begin
      rd_cyc_q <= rd_cyc;
      wr_cyc_q <= wr_cyc;
      if (!rd_cyc) rd_guard <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_pend <= 1'b0;
    end else if (flush) begin
      pop_pend <= 1'b0;
    end else if (rd_rise && data_hit) begin
      pop_pend <= ~fifo_empty;
    end else if (rd_fall) begin
      pop_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (ovr_set) begin
      overrun_q <= 1'b1;
    end else if (clr_ovr) begin
      overrun_q <= 1'b0;
    end
  end

  always_comb begin
    rd_sel    = RD_NONE;
    dbus_next = 8'h00;
    if (rd_cyc && data_hit) begin
      rd_sel = RD_DATA;
    end else if (rd_cyc && status_hit) begin
      rd_sel = RD_STATUS;
    end
    case (rd_sel)
      RD_DATA:   dbus_next = fifo_empty ? 8'h00 : fifo_head;
      RD_STATUS: dbus_next = status_byte(overrun_q, fifo_full, ~fifo_empty);
      default:   dbus_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbus_out <= 8'h00;
    end else begin
      dbus_out <= dbus_next;
    end
  end

  assign rx_avail   = ~fifo_empty;
  assign char_ready = ~fifo_full;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_z80_char_in_port.sv
module tb_z80_char_in_port;

  localparam int DEPTH = 16;

  logic       clk;
  logic       reset;
  logic [7:0] address;
  logic       iorq_n, rd_n, wr_n;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic [7:0] char_in;
  logic       char_stb;
  logic       char_ready, rx_avail, overrun;

  int checks;
  int errors;

  // Reference model: plain byte queue plus sticky overrun bit
  logic [7:0] model_q[$];
  logic       model_ovr;

  z80_char_in_port #(.DEPTH(16), .AW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .dbus_in    (dbus_in),
    .dbus_out   (dbus_out),
    .char_in    (char_in),
    .char_stb   (char_stb),
    .char_ready (char_ready),
    .rx_avail   (rx_avail),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_status();
    logic full_b, avail_b;
    full_b  = (model_q.size() == DEPTH);
    avail_b = (model_q.size() != 0);
    return {5'b00000, model_ovr, full_b, avail_b};
  endfunction

  function automatic logic [7:0] model_pop();
    if (model_q.size() == 0) return 8'h00;
    return model_q.pop_front();
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() == DEPTH) model_ovr = 1'b1;
    else model_q.push_back(b);
  endtask

  // All stimulus tasks start and end at posedge+1.
  task automatic push_byte(input logic [7:0] b);
    char_in  = b;
    char_stb = 1'b1;
    @(posedge clk); #1;
    char_stb = 1'b0;
    model_push(b);
  endtask

  task automatic io_read(input logic [7:0] a, input int len,
                         output logic [7:0] d, output bit stable);
    address = a;
    iorq_n  = 1'b0;
    rd_n    = 1'b0;
    stable  = 1'b1;
    d       = 8'h00;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      if (i == 0) d = dbus_out;
      else if (dbus_out !== d) stable = 1'b0;
    end
    iorq_n  = 1'b1;
    rd_n    = 1'b1;
    address = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] v);
    address = a;
    dbus_in = v;
    iorq_n  = 1'b0;
    wr_n    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    iorq_n  = 1'b1;
    wr_n    = 1'b1;
    address = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dbus_out !== 8'h00) begin errors++; $display("FAIL reset_dbus: got %h expected 00", dbus_out); end
    checks++;
    if (rx_avail !== 1'b0) begin errors++; $display("FAIL reset_rx_avail: got %b expected 0", rx_avail); end
    checks++;
    if (char_ready !== 1'b1) begin errors++; $display("FAIL reset_char_ready: got %b expected 1", char_ready); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    reset = 1'b0;
    @(posedge clk); #1;
    model_q.delete();
    model_ovr = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] d, e;
    bit st;
    push_byte(8'h41);
    push_byte(8'h42);
    io_read(8'hBA, 1, d, st);
    e = model_pop();
    checks++;
    if (d !== e) begin errors++; $display("FAIL basic_first: got %h expected %h", d, e); end
    checks++;
    if (rx_avail !== 1'b1) begin errors++; $display("FAIL basic_avail1: got %b expected 1", rx_avail); end
    io_read(8'hBA, 1, d, st);
    e = model_pop();
    checks++;
    if (d !== e) begin errors++; $display("FAIL basic_second: got %h expected %h", d, e); end
    checks++;
    if (rx_avail !== 1'b0) begin errors++; $display("FAIL basic_avail0: got %b expected 0", rx_avail); end
  endtask

  task automatic test_long_read();
    logic [7:0] d, e;
    bit st;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
    io_read(8'hBA, 6, d, st);
    e = model_pop();
    checks++;
    if (d !== e) begin errors++; $display("FAIL long_read_data: got %h expected %h", d, e); end
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL long_read_stable: got %b expected 1", st); end
    // Exactly one pop: the remaining two bytes come out in order, then empty.
    for (int i = 0; i < 3; i++) begin
      io_read(8'hBA, 1, d, st);
      e = model_pop();
      checks++;
      if (d !== e) begin errors++; $display("FAIL long_read_drain%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_fill_overrun();
    logic [7:0] d, e;
    bit st;
    for (int i = 0; i <= DEPTH; i++) begin
      push_byte(8'(i));
      if (i == DEPTH - 2) begin
        checks++;
        if (char_ready !== 1'b1) begin errors++; $display("FAIL fill_ready15: got %b expected 1", char_ready); end
      end
      if (i == DEPTH - 1) begin
        checks++;
        if (char_ready !== 1'b0) begin errors++; $display("FAIL fill_ready16: got %b expected 0", char_ready); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL fill_ovr16: got %b expected 0", overrun); end
      end
    end
    checks++;
    if (overrun !== model_ovr) begin errors++; $display("FAIL fill_ovr17: got %b expected %b", overrun, model_ovr); end
    io_read(8'hBC, 1, d, st);
    e = exp_status();
    checks++;
    if (d !== e) begin errors++; $display("FAIL fill_status: got %h expected %h", d, e); end
  endtask

  task automatic test_clr_overrun();
    logic [7:0] d, e;
    bit st;
    // Clear request and a full-FIFO strobe on the same edge: set wins.
    address  = 8'hBC;
    dbus_in  = 8'h04;
    iorq_n   = 1'b0;
    wr_n     = 1'b0;
    char_in  = 8'hEE;
    char_stb = 1'b1;
    @(posedge clk); #1;
    char_stb = 1'b0;
    model_push(8'hEE);
    @(posedge clk); #1;
    iorq_n   = 1'b1;
    wr_n     = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b expected 1", overrun); end
    io_write(8'hBC, 8'h04);
    model_ovr = 1'b0;
    io_read(8'hBC, 1, d, st);
    e = exp_status();
    checks++;
    if (d !== e) begin errors++; $display("FAIL clr_status: got %h expected %h", d, e); end
    for (int i = 0; i <= DEPTH; i++) begin
      io_read(8'hBA, 1, d, st);
      e = model_pop();
      checks++;
      if (d !== e) begin errors++; $display("FAIL drain%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] d, e, b;
    bit st;
    for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
    address  = 8'hBC;
    dbus_in  = 8'h80;
    iorq_n   = 1'b0;
    wr_n     = 1'b0;
    char_in  = 8'h5A;
    char_stb = 1'b1;
    @(posedge clk); #1;
    char_stb = 1'b0;
    model_q.delete();
    @(posedge clk); #1;
    iorq_n   = 1'b1;
    wr_n     = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rx_avail !== 1'b0) begin errors++; $display("FAIL flush_avail: got %b expected 0", rx_avail); end
    io_read(8'hBC, 1, d, st);
    e = exp_status();
    checks++;
    if (d !== e) begin errors++; $display("FAIL flush_status: got %h expected %h", d, e); end
    io_read(8'hBA, 1, d, st);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL flush_data: got %h expected 00", d); end
    b = 8'($urandom_range(0, 255));
    push_byte(b);
    io_read(8'hBA, 1, d, st);
    e = model_pop();
    checks++;
    if (d !== e) begin errors++; $display("FAIL flush_reuse: got %h expected %h", d, e); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d, e, b;
    bit st;
    push_byte(8'hA1);
    push_byte(8'hA2);
    address = 8'hBA;
    iorq_n  = 1'b0;
    rd_n    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (dbus_out !== 8'h00) begin errors++; $display("FAIL rst_mid_dbus_async: got %h expected 00", dbus_out); end
    model_q.delete();
    model_ovr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dbus_out !== 8'h00) begin errors++; $display("FAIL rst_mid_dbus: got %h expected 00", dbus_out); end
    checks++;
    if (rx_avail !== 1'b0) begin errors++; $display("FAIL rst_mid_empty: got %b expected 0", rx_avail); end
    // Queue a byte while the straddling read is still held; ending that
    // read must not consume it.
    b = 8'($urandom_range(0, 255));
    push_byte(b);
    @(posedge clk); #1;
    iorq_n  = 1'b1;
    rd_n    = 1'b1;
    address = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (rx_avail !== 1'b1) begin errors++; $display("FAIL rst_mid_no_pop: got %b expected 1", rx_avail); end
    io_read(8'hBA, 1, d, st);
    e = model_pop();
    checks++;
    if (d !== e) begin errors++; $display("FAIL rst_mid_byte: got %h expected %h", d, e); end
  endtask

  task automatic test_random();
    logic [7:0] d, e, v, a;
    bit st;
    int op;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        push_byte(8'($urandom_range(0, 255)));
      end else if (op <= 5) begin
        io_read(8'hBA, $urandom_range(1, 4), d, st);
        e = model_pop();
        checks++;
        if (d !== e) begin errors++; $display("FAIL rnd_data it=%0d: got %h expected %h", it, d, e); end
        checks++;
        if (st !== 1'b1) begin errors++; $display("FAIL rnd_stable it=%0d: got %b expected 1", it, st); end
      end else if (op == 6) begin
        io_read(8'hBC, $urandom_range(1, 3), d, st);
        e = exp_status();
        checks++;
        if (d !== e) begin errors++; $display("FAIL rnd_status it=%0d: got %h expected %h", it, d, e); end
      end else if (op == 7) begin
        v = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) v[7] = 1'b0;
        io_write(8'hBC, v);
        if (v[7]) model_q.delete();
        if (v[2]) model_ovr = 1'b0;
      end else if (op == 8) begin
        a = 8'($urandom_range(0, 255));
        if (a == 8'hBC) a = 8'hBA;
        io_write(a, 8'($urandom_range(0, 255)));
      end else begin
        a = 8'($urandom_range(0, 255));
        if (a == 8'hBA || a == 8'hBC) a = 8'h00;
        io_read(a, 1, d, st);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL rnd_other it=%0d addr=%h: got %h expected 00", it, a, d); end
      end
      checks++;
      if ({overrun, char_ready, rx_avail} !== {model_ovr, model_q.size() != DEPTH, model_q.size() != 0}) begin
        errors++;
        $display("FAIL rnd_flags it=%0d: got ovr/ready/avail %b%b%b expected %b%b%b", it,
                 overrun, char_ready, rx_avail, model_ovr, model_q.size() != DEPTH, model_q.size() != 0);
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_ovr = 1'b0;
    address   = 8'h00;
    iorq_n    = 1'b1;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    dbus_in   = 8'h00;
    char_in   = 8'h00;
    char_stb  = 1'b0;
    reset     = 1'b1;
    test_reset();
    test_basic();
    test_long_read();
    test_fill_overrun();
    test_clr_overrun();
    test_flush();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
